fifo_tx_pop_sequencer: RTL

Pop-side controller for the multi-push/multi-pop byte FIFO in the UART path. It issues multi-element pop requests sized to what the FIFO can deliver, stages up to N words locally, and serialises them one word per handshake toward the UART transmitter. It is the only agent driving the FIFO `pop` port, and it converts the FIFO's N-wide pop bus into a single-word valid/ready stream.

---
 rtl/fifo_tx_pop_sequencer.sv | 103 ++++++++++
 1 files changed

// File: rtl/fifo_tx_pop_sequencer.sv
// Pop-side sequencer: pulls up to N words from the multi-pop FIFO and serialises them on a valid/ready stream.
// Optional feature macro: TX_POP_PREFETCH_EN (reload the stage on the last handshake of a burst).
module fifo_tx_pop_sequencer #(
  parameter int W  = 8,
  parameter int N  = 4,
  parameter int WN = $clog2(N+1)+1
) (
  input  logic           clk,
  input  logic           arstn,
  input  logic           en,
  input  logic [WN-1:0]  fifo_can_pop,
  input  logic [N*W-1:0] fifo_pop_data,
  output logic [WN-1:0]  fifo_pop,
  output logic [W-1:0]   tx_data,
  output logic           tx_valid,
  input  logic           tx_ready,
  output logic           busy,
  output logic [15:0]    tx_cnt
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

`ifdef TX_POP_PREFETCH_EN
  localparam bit PREFETCH = 1'b1;
`else
  localparam bit PREFETCH = 1'b0;
`endif

  typedef enum logic {EMPTY, DRAIN} state_t;

  state_t        state;
  logic [W-1:0]  stg [N];
  logic [IW-1:0] rd_idx;
  logic [WN-1:0] stg_cnt;
  logic [WN-1:0] avail;
  logic          hs;
  logic          last;

  always_comb begin
    avail = (fifo_can_pop > WN'(N)) ? WN'(N) : fifo_can_pop;
  end

  assign hs   = (state == DRAIN) && tx_ready;
  assign last = (stg_cnt == WN'(1));

  // Reset gates the pop request so nothing leaves the FIFO while the stage is being discarded.
  always_comb begin
    fifo_pop = '0;
    if (en && arstn) begin
      if (state == EMPTY)
        fifo_pop = avail;
      else if (PREFETCH && hs && last)
        fifo_pop = avail;
    end
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state   <= EMPTY;
      stg_cnt <= '0;
      rd_idx  <= '0;
      tx_cnt  <= '0;
    end else begin
      case (state)
        EMPTY: begin
          if (fifo_pop != '0) begin
            state   <= DRAIN;
            stg_cnt <= fifo_pop;
            rd_idx  <= '0;
          end
        end
        DRAIN: begin
          if (tx_ready) begin
            tx_cnt <= tx_cnt + 16'd1;
            if (last) begin
              // fifo_pop is only nonzero here when prefetch reloads the stage
              rd_idx  <= '0;
              stg_cnt <= fifo_pop;
              if (fifo_pop == '0)
                state <= EMPTY;
            end else begin
              rd_idx  <= rd_idx + IW'(1);
              stg_cnt <= stg_cnt - WN'(1);
            end
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (WN'(i) < fifo_pop)
        stg[i] <= fifo_pop_data[i*W +: W];
    end
  end

  assign tx_valid = (state == DRAIN);
  assign busy     = tx_valid;
  assign tx_data  = tx_valid ? stg[rd_idx] : '0;

endmodule
